// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller.
// Optional perf counters are enabled with PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_e;

    localparam int DRAIN_CYCLES_DEFAULT = 2;
    localparam int CNT_W                = 16;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: hazard inputs from ID/EX/MEM and the stall/flush/freeze outputs.
// Outputs are level signals, valid in the same cycle as the inputs that produce them.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [2:0]       Rs_ID;
    logic [2:0]       Rt_ID;
    logic             RsVal_ID;
    logic             RtVal_ID;
    logic             MemRead_IDEX;
    logic             RegWrite_IDEX;
    logic [2:0]       WrR_IDEX;
    logic             takeBranch;
    logic             takeBranch_EXMEM;
    logic             halt_IDEX;
    logic             dmemStall;

    logic             freeze;
    logic             stall_IFID;
    logic             bubble_IDEX;
    logic             flush_IFID;
    logic             halted;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output Rs_ID, Rt_ID, RsVal_ID, RtVal_ID, MemRead_IDEX, RegWrite_IDEX, WrR_IDEX,
               takeBranch, takeBranch_EXMEM, halt_IDEX, dmemStall,
        input  freeze, stall_IFID, bubble_IDEX, flush_IFID, halted, stallCnt, flushCnt
    );

    modport slave (
        input  Rs_ID, Rt_ID, RsVal_ID, RtVal_ID, MemRead_IDEX, RegWrite_IDEX, WrR_IDEX,
               takeBranch, takeBranch_EXMEM, halt_IDEX, dmemStall,
        output freeze, stall_IFID, bubble_IDEX, flush_IFID, halted, stallCnt, flushCnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module hazard_detect (
    input  logic [2:0] rs_id,
    input  logic [2:0] rt_id,
    input  logic       rs_val_id,
    input  logic       rt_val_id,
    input  logic       mem_read_idex,
    input  logic       reg_write_idex,
    input  logic [2:0] wr_r_idex,
    output logic       load_use
);

    always_comb begin
        load_use = mem_read_idex & reg_write_idex &
                   ((rs_val_id & (rs_id == wr_r_idex)) |
                    (rt_val_id & (rt_id == wr_r_idex)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, branch flush, dmem freeze and halt drain.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus,
    output state_e       dbg_state
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_use;
    logic          freeze, stall, bubble, flush, halted;

    hazard_detect u_hazard (
        .rs_id          (bus.Rs_ID),
        .rt_id          (bus.Rt_ID),
        .rs_val_id      (bus.RsVal_ID),
        .rt_val_id      (bus.RtVal_ID),
        .mem_read_idex  (bus.MemRead_IDEX),
        .reg_write_idex (bus.RegWrite_IDEX),
        .wr_r_idex      (bus.WrR_IDEX),
        .load_use       (load_use)
    );

    // Priority: halted, dmem freeze, drain, taken branch, load-use.
    always_comb begin
        halted = (state_q == HALTED);
        freeze = halted | bus.dmemStall;
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!freeze) begin
            if (state_q == DRAIN) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else if (bus.takeBranch) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (load_use) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            case (state_q)
                RUN: begin
                    if (bus.halt_IDEX && !bus.takeBranch_EXMEM) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) state_d = HALTED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                HALTED:  ;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.freeze      = freeze;
    assign bus.stall_IFID  = stall;
    assign bus.bubble_IDEX = bubble;
    assign bus.flush_IFID  = flush;
    assign bus.halted      = halted;
    assign dbg_state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, (stall | freeze) & ~halted);
        flush_cnt_d = sat_inc(flush_cnt_q, flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stallCnt = stall_cnt_q;
    assign bus.flushCnt = flush_cnt_q;
`else
    assign bus.stallCnt = '0;
    assign bus.flushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DC = 2;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural model ----------------
  int         checks = 0;
  int         errors = 0;
  bit         m_halted, m_draining;
  int         m_left;
  int         m_stall_cnt, m_flush_cnt;
  logic [4:0] m_out;          // {freeze, stall, bubble, flush, halted}
  logic [4:0] exp_q[$];

  function automatic logic [4:0] model_out();
    bit lu;
    lu = bus.MemRead_IDEX && bus.RegWrite_IDEX &&
         ((bus.RsVal_ID && (bus.Rs_ID == bus.WrR_IDEX)) ||
          (bus.RtVal_ID && (bus.Rt_ID == bus.WrR_IDEX)));
    if (m_halted || bus.dmemStall) return {1'b1, 3'b000, m_halted};
    if (m_draining)                return 5'b01100;
    if (bus.takeBranch)            return 5'b00110;
    if (lu)                        return 5'b01100;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] outs();
    return {bus.freeze, bus.stall_IFID, bus.bubble_IDEX, bus.flush_IFID, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare (per cycle, #1 after negedge) ----------------
  task automatic settle();
    logic [4:0] exp;
    state_e     exp_st;
    #1;
    m_out = model_out();
    if (!rst) begin
      exp_q.push_back(m_out);
      exp    = exp_q.pop_front();
      exp_st = m_halted ? HALTED : (m_draining ? DRAIN : RUN);
      chk("ctrl_outputs", 32'(outs()), 32'(exp));
      chk("state", 32'(dbg_state), 32'(exp_st));
      chk("stallCnt", 32'(bus.stallCnt), PERF ? 32'(m_stall_cnt) : 32'd0);
      chk("flushCnt", 32'(bus.flushCnt), PERF ? 32'(m_flush_cnt) : 32'd0);
    end
  endtask

  // ---------------- model update at the rising edge ----------------
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_halted    = 1'b0;
      m_draining  = 1'b0;
      m_left      = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if ((m_out[4] || m_out[3]) && !m_halted && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_out[1] && m_flush_cnt < 65535) m_flush_cnt++;
      if (!m_halted && !bus.dmemStall) begin
        if (m_draining) begin
          m_left--;
          if (m_left == 0) begin
            m_draining = 1'b0;
            m_halted   = 1'b1;
          end
        end else if (bus.halt_IDEX && !bus.takeBranch_EXMEM) begin
          m_draining = 1'b1;
          m_left     = DC;
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    bus.Rs_ID = 3'd0; bus.Rt_ID = 3'd0; bus.RsVal_ID = 1'b0; bus.RtVal_ID = 1'b0;
    bus.MemRead_IDEX = 1'b0; bus.RegWrite_IDEX = 1'b0; bus.WrR_IDEX = 3'd0;
    bus.takeBranch = 1'b0; bus.takeBranch_EXMEM = 1'b0; bus.halt_IDEX = 1'b0;
    bus.dmemStall = 1'b0;
  endtask

  task automatic set_lu();
    bus.Rs_ID = 3'd3; bus.RsVal_ID = 1'b1; bus.MemRead_IDEX = 1'b1;
    bus.RegWrite_IDEX = 1'b1; bus.WrR_IDEX = 3'd3;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.Rs_ID            = 3'($urandom_range(0, 7));
    bus.Rt_ID            = 3'($urandom_range(0, 7));
    bus.RsVal_ID         = 1'($urandom_range(0, 1));
    bus.RtVal_ID         = 1'($urandom_range(0, 1));
    bus.MemRead_IDEX     = 1'($urandom_range(0, 1));
    bus.RegWrite_IDEX    = ($urandom_range(0, 3) != 0);
    bus.WrR_IDEX         = ($urandom_range(0, 1) == 1) ? bus.Rs_ID : 3'($urandom_range(0, 7));
    bus.takeBranch       = m_draining ? 1'b0 : ($urandom_range(0, 6) == 0);
    bus.takeBranch_EXMEM = ($urandom_range(0, 2) == 0);
    bus.halt_IDEX        = ($urandom_range(0, 19) == 0);
    bus.dmemStall        = ($urandom_range(0, 6) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // reset state
    settle();
    chk("rst_outputs", 32'(outs()), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(RUN));
    chk("rst_stallCnt", 32'(bus.stallCnt), 32'h0);
    advance();

    // load-use stalls one cycle, then the load has moved on
    set_lu();
    settle();
    chk("lu_stall", 32'(outs()), 32'b01100);
    advance();
    bus.MemRead_IDEX = 1'b0;
    settle();
    chk("lu_release", 32'(outs()), 32'h0);
    advance();

    // taken branch overrides a coincident load-use
    set_lu();
    bus.takeBranch = 1'b1;
    settle();
    chk("br_over_lu", 32'(outs()), 32'b00110);
    advance();
    idle();
    settle();
    chk("br_flushCnt", 32'(bus.flushCnt), PERF ? 32'd1 : 32'd0);
    advance();

    // halt squashed by a prior redirect is ignored
    bus.halt_IDEX = 1'b1;
    bus.takeBranch_EXMEM = 1'b1;
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("squash_state", 32'(dbg_state), 32'(RUN));
      chk("squash_halted", 32'(bus.halted), 32'h0);
      advance();
    end

    // drain frozen for 3 cycles, then DC unfrozen cycles, then halted
    bus.halt_IDEX = 1'b1;
    step();
    idle();
    bus.dmemStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_freeze", 32'(outs()), 32'b10000);
      advance();
    end
    bus.dmemStall = 1'b0;
    for (int i = 0; i < DC; i++) begin
      settle();
      chk("drain_run", 32'(outs()), 32'b01100);
      advance();
    end
    settle();
    chk("halted", 32'(outs()), 32'b10001);
    advance();
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      settle();
      chk("halt_sticky", 32'(bus.halted), 32'h1);
      advance();
    end

    // reset in the middle of a drain, then a full fresh drain
    do_reset();
    bus.halt_IDEX = 1'b1;
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rst_drain_halted", 32'(bus.halted), 32'h0);
    chk("rst_drain_state", 32'(dbg_state), 32'(RUN));
    advance();
    bus.halt_IDEX = 1'b1;
    step();
    idle();
    for (int i = 0; i < DC; i++) begin
      settle();
      chk("redrain_busy", 32'(outs()), 32'b01100);
      advance();
    end
    settle();
    chk("redrain_done", 32'(bus.halted), 32'h1);
    advance();
    do_reset();

    // randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst = (m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0);
      rand_inputs();
      step();
    end
    rst = 1'b0;

`ifdef PIPE_CTRL_PERF_EN
    // stall counter saturation
    do_reset();
    idle();
    bus.dmemStall = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    settle();
    chk("stall_sat", 32'(bus.stallCnt), 32'h0000FFFF);
    advance();
    for (int i = 0; i < 3; i++) step();
    settle();
    chk("stall_sat_hold", 32'(bus.stallCnt), 32'h0000FFFF);
    advance();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 2, number of cycles after a halt leaves EX before halted asserts (EX/MEM and MEM/WB retire).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Rs_ID, Rt_ID  in  3 each  source register numbers of the instruction in ID.
REQ-005 RsVal_ID, RtVal_ID  in  1 each  the corresponding source is actually read.
REQ-006 MemRead_IDEX, RegWrite_IDEX  in  1 each  the instruction in EX is a load or writes a register.
REQ-007 WrR_IDEX  in  3  destination register of the instruction in EX.
REQ-008 takeBranch  in  1  branch or jump resolved taken in EX this cycle.
REQ-009 takeBranch_EXMEM  in  1  the EX slot is squashed by the prior redirect.
REQ-010 halt_IDEX  in  1  halt instruction in EX.
REQ-011 dmemStall  in  1  data memory is not ready.
REQ-012 freeze  out  1  hold every pipeline register and the PC.
REQ-013 stall_IFID  out  1  hold the PC and the IF/ID register.
REQ-014 bubble_IDEX  out  1  load a NOP (all write enables 0) into ID/EX.
REQ-015 flush_IFID  out  1  squash IF/ID.
REQ-016 halted  out  1  the pipeline is drained and stopped.
REQ-017 stallCnt, flushCnt  out  16 each  performance counters (see Configuration).

Function
REQ-018 States: RUN, DRAIN, HALTED. The state register is the only sequential control state besides the drain counter and the perf counters.
REQ-019 Load-use hazard = MemRead_IDEX & RegWrite_IDEX & ((RsVal_ID & Rs_ID==WrR_IDEX) | (RtVal_ID & Rt_ID==WrR_IDEX)).
REQ-020 Output priority, highest first: halted, then dmemStall, then takeBranch, then load-use.
REQ-021 While halted=1: freeze=1, and all other control outputs are 0.
REQ-022 When dmemStall=1 and the state is not HALTED: freeze=1, other control outputs are 0, and the state and drain counter hold.
REQ-023 When takeBranch=1 and not frozen: flush_IFID=1 and bubble_IDEX=1 in the same cycle, and stall_IFID=0. A coincident load-use hazard is discarded.
REQ-024 When load-use is active, not frozen and not taken: stall_IFID=1 and bubble_IDEX=1 for exactly one cycle. The next cycle shows no hazard, because the load has moved to EX/MEM.
REQ-025 All control outputs are combinational from the current state and the inputs, with zero latency.
REQ-026 RUN -> DRAIN when halt_IDEX & ~takeBranch_EXMEM & ~dmemStall. The drain counter loads DRAIN_CYCLES-1.
REQ-027 In DRAIN: stall_IFID=1 and bubble_IDEX=1 every unfrozen cycle. The counter decrements each unfrozen cycle. At 0 the state goes to HALTED.
REQ-028 A halt with takeBranch_EXMEM=1 is ignored and the state stays RUN.
REQ-029 HALTED is exited only by rst.
REQ-030 rst asserted in the middle of DRAIN returns the block to RUN with the counter at 0.

Reset
REQ-031 On rst: state=RUN, drain counter=0, stallCnt=0, flushCnt=0. All outputs are 0 in the cycle after reset.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_EN, when defined:
- stallCnt increments on every cycle with stall_IFID=1 or freeze=1 while not HALTED.
- flushCnt increments on every cycle with flush_IFID=1.
- Both counters saturate at 16'hFFFF.
REQ-033 When PIPE_CTRL_PERF_EN is undefined, stallCnt and flushCnt are tied to 16'h0000, no counter flops exist, and the ports remain present.

Structure
REQ-034 Shared package pipe_ctrl_pkg holds:
- the state enum (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10);
- the DRAIN_CYCLES default;
- the counter width constant (16).
REQ-035 Sub-module hazard_detect is purely combinational and computes the REQ-019 compare. pipe_ctrl instantiates it once.

Verification
REQ-036 Load-use: Rs_ID=3, RsVal_ID=1, MemRead_IDEX=1, RegWrite_IDEX=1, WrR_IDEX=3 -> stall_IFID=1 and bubble_IDEX=1 for exactly 1 cycle; then with MemRead_IDEX=0 both go to 0.
REQ-037 Branch over hazard: takeBranch=1 together with the REQ-036 hazard -> flush_IFID=1, bubble_IDEX=1, stall_IFID=0; flushCnt increments by 1 (PERF_EN).
REQ-038 Freeze: dmemStall=1 for 3 cycles during DRAIN with DRAIN_CYCLES=2 -> freeze=1 for those 3 cycles, then 2 unfrozen cycles, then halted=1.
REQ-039 Squashed halt: halt_IDEX=1 with takeBranch_EXMEM=1 -> state stays RUN and halted never asserts.
REQ-040 Reset during DRAIN: rst=1 for 1 cycle -> halted=0 and state RUN on the next cycle; a new halt then takes the full DRAIN_CYCLES.
REQ-041 Saturation (PERF_EN): hold stall_IFID for 70000 cycles -> stallCnt=16'hFFFF and it stays there.
